// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants and helpers for the TMDS receive channel.
package tmds_pkg;

    localparam int unsigned SYM_W    = 10;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OFFSET_W = 4;

    // Control-period tokens, named by the {c1,c0} pair they carry
    localparam logic [SYM_W-1:0] TOKEN_C00 = 10'h354;
    localparam logic [SYM_W-1:0] TOKEN_C01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOKEN_C10 = 10'h154;
    localparam logic [SYM_W-1:0] TOKEN_C11 = 10'h2AB;

    // Alignment FSM states
    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // True when the word is one of the four control tokens
    function automatic logic is_ctrl_token(input logic [SYM_W-1:0] w);
        return (w == TOKEN_C00) || (w == TOKEN_C01) ||
               (w == TOKEN_C10) || (w == TOKEN_C11);
    endfunction

    // Control bits carried by a token; non-tokens map to 00 and are never used
    function automatic logic [1:0] token_ctrl(input logic [SYM_W-1:0] w);
        logic [1:0] c;
        c = 2'b00;
        case (w)
            TOKEN_C01: c = 2'b01;
            TOKEN_C10: c = 2'b10;
            TOKEN_C11: c = 2'b11;
            default:   c = 2'b00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: registered 10b -> 8b / control decode of one aligned
// TMDS word. Outputs are forced to zero while i_en is low (not yet aligned).
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [SYM_W-1:0]  i_word,
    output logic [DATA_W-1:0] o_data,
    output logic              o_de,
    output logic [1:0]        o_ctrl
);

    logic [DATA_W-1:0] r_data;
    logic              r_de;
    logic [1:0]        r_ctrl;

    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] w_dec;
    logic              w_is_ctrl;
    logic [1:0]        w_ctrl_code;

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        w_q      = i_word[9] ? ~i_word[DATA_W-1:0] : i_word[DATA_W-1:0];
        w_dec    = '0;
        w_dec[0] = w_q[0];
        for (int i = 1; i < DATA_W; i++) begin
            w_dec[i] = i_word[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
        w_is_ctrl   = is_ctrl_token(i_word);
        w_ctrl_code = token_ctrl(i_word);
    end

    // Output stage: tokens update ctrl and hold data, data words do the reverse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else if (!i_en) begin
            r_data <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else if (w_is_ctrl) begin
            r_de   <= 1'b0;
            r_ctrl <= w_ctrl_code;
        end else begin
            r_de   <= 1'b1;
            r_data <= w_dec;
        end
    end

    assign o_data = r_data;
    assign o_de   = r_de;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS receive channel. Finds the 10-bit word
// boundary by bit-slipping until runs of control tokens show up inside an
// alignment window, keeps checking that runs keep appearing, and decodes
// the aligned words into pixel data / DE / control bits.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned C_lock_count  = 8,
    parameter int unsigned C_window_bits = 16
) (
    input  logic                i_clk_pixel,
    input  logic                i_reset,
    input  logic [SYM_W-1:0]    i_sym_in,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_de,
    output logic [1:0]          o_ctrl,
    output logic                o_locked,
    output logic [OFFSET_W-1:0] o_offset,
    output logic                o_slip
);

    localparam int unsigned         RUN_W       = 4;
    localparam int unsigned         WIN_W       = C_window_bits;
    localparam logic [RUN_W-1:0]    RUN_TARGET  = RUN_W'(C_lock_count);
    localparam logic [OFFSET_W-1:0] OFFSET_LAST = OFFSET_W'(SYM_W - 1);

    logic [SYM_W-1:0]    r_sym_prev;
    logic [SYM_W-1:0]    r_stage1;
    logic [OFFSET_W-1:0] r_offset;
    logic [0:0]          r_state;
    logic [RUN_W-1:0]    r_run;
    logic [WIN_W-1:0]    r_win;
    logic                r_seen_run;
    logic                r_slip;

    logic [2*SYM_W-1:0]  w_pair;
    logic [SYM_W-1:0]    w_aligned;
    logic                w_is_ctrl;
    logic [RUN_W-1:0]    w_run_inc;
    logic                w_run_done;
    logic                w_expire;
    logic [OFFSET_W-1:0] w_offset_inc;

    logic [0:0]          w_state_next;
    logic [OFFSET_W-1:0] w_offset_next;
    logic [RUN_W-1:0]    w_run_next;
    logic [WIN_W-1:0]    w_win_next;
    logic                w_seen_next;
    logic                w_slip;
    logic                w_out_en;

    // Slip mux: pick the 10-bit window starting r_offset bits into the previous word
    always_comb begin
        w_pair    = {i_sym_in, r_sym_prev};
        w_aligned = SYM_W'(w_pair >> r_offset);
    end

    // Event detection on the stage-1 word and the window counter
    always_comb begin
        w_is_ctrl    = is_ctrl_token(r_stage1);
        w_run_inc    = (r_run >= RUN_TARGET) ? RUN_TARGET : (r_run + RUN_W'(1));
        w_run_done   = w_is_ctrl && (r_run == (RUN_TARGET - RUN_W'(1)));
        w_expire     = &r_win;
        w_offset_inc = (r_offset == OFFSET_LAST) ? '0 : (r_offset + OFFSET_W'(1));
    end

    // Alignment FSM next state; a completed run always beats a window expiry
    always_comb begin
        w_state_next  = r_state;
        w_seen_next   = r_seen_run;
        w_slip        = 1'b0;
        w_win_next    = r_win + WIN_W'(1);
        w_run_next    = w_is_ctrl ? w_run_inc : '0;
        w_offset_next = r_offset;

        case (r_state)
            ST_SEARCH: begin
                if (w_run_done) begin
                    w_state_next = ST_LOCKED;
                    w_win_next   = '0;
                end else if (w_expire) begin
                    w_slip = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_run_done) begin
                    w_seen_next = 1'b1;
                end else if (w_expire) begin
                    if (r_seen_run) begin
                        w_seen_next = 1'b0;
                    end else begin
                        w_state_next = ST_SEARCH;
                        w_slip       = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
            end
        endcase

        // A slip restarts both the window and the run; the word straddling it is discarded
        if (w_slip) begin
            w_offset_next = w_offset_inc;
            w_run_next    = '0;
            w_win_next    = '0;
        end
    end

    // Output enable follows the state being entered so the locking token is decoded
    assign w_out_en = (w_state_next == ST_LOCKED);

    // Input history and stage-1 aligned word
    always_ff @(posedge i_clk_pixel) begin
        if (i_reset) begin
            r_sym_prev <= '0;
            r_stage1   <= '0;
        end else begin
            r_sym_prev <= i_sym_in;
            r_stage1   <= w_aligned;
        end
    end

    // Alignment FSM state, counters and slip pulse
    always_ff @(posedge i_clk_pixel) begin
        if (i_reset) begin
            r_state    <= ST_SEARCH;
            r_offset   <= '0;
            r_run      <= '0;
            r_win      <= '0;
            r_seen_run <= 1'b0;
            r_slip     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_offset   <= w_offset_next;
            r_run      <= w_run_next;
            r_win      <= w_win_next;
            r_seen_run <= w_seen_next;
            r_slip     <= w_slip;
        end
    end

    tmds_symbol_decode u_decode (
        .i_clk   (i_clk_pixel),
        .i_reset (i_reset),
        .i_en    (w_out_en),
        .i_word  (r_stage1),
        .o_data  (o_data),
        .o_de    (o_de),
        .o_ctrl  (o_ctrl)
    );

    assign o_locked = (r_state == ST_LOCKED);
    assign o_offset = r_offset;
    assign o_slip   = r_slip;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: scoreboard bench. The stimulus side feeds a rotated
// TMDS symbol stream and pushes the expected outputs of a reference model; a
// monitor pops one expectation per clock and compares every output.
module tb_tmds_channel_decoder;

    localparam int unsigned LOCK      = 8;
    localparam int unsigned WINB      = 8;
    localparam int unsigned WIN       = 256;
    localparam int unsigned LINE_TOK  = 12;
    localparam int unsigned LINE_DATA = 52;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [9:0] i_sym_in;
    logic [7:0] o_data;
    logic       o_de;
    logic [1:0] o_ctrl;
    logic       o_locked;
    logic [3:0] o_offset;
    logic       o_slip;

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .C_lock_count  (LOCK),
        .C_window_bits (WINB)
    ) dut (
        .i_clk_pixel (clk),
        .i_reset     (i_reset),
        .i_sym_in    (i_sym_in),
        .o_data      (o_data),
        .o_de        (o_de),
        .o_ctrl      (o_ctrl),
        .o_locked    (o_locked),
        .o_offset    (o_offset),
        .o_slip      (o_slip)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       de;
        logic [1:0] ctrl;
        logic       locked;
        logic [3:0] offset;
        logic       slip;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   drive_cyc = 0;

    // monitor-collected events
    int   slip_cnt = 0;
    int   slip_cyc[$];
    int   lock_rise_cyc = -1;
    int   fall_cnt = 0;
    int   fall_off = -1;
    int   fall_slip = 0;
    logic prev_locked = 1'b0;

    // stream generator state
    int         rot = 0;
    logic [9:0] last_sym = '0;

    // reference model state
    logic [9:0] m_prev = '0;
    logic [9:0] m_word = '0;
    int         m_off = 0;
    int         m_run = 0;
    int         m_timer = 0;
    bit         m_lock = 0;
    bit         m_seen = 0;
    logic [7:0] m_data = '0;
    logic       m_de = 1'b0;
    logic [1:0] m_ctrl = 2'b00;

    // control bits of a token, or -1 for a data word
    function automatic int token_of(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    // decode by finding the byte whose TMDS encoding (with this word's bit8/bit9) gives w
    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] dv;
        logic [7:0] result;
        bit         found;
        result = 8'h00;
        found  = 0;
        for (int d = 0; d < 256; d++) begin
            if (!found) begin
                dv   = 8'(d);
                q    = '0;
                q[0] = dv[0];
                for (int i = 1; i < 8; i++) begin
                    q[i] = w[8] ? (q[i-1] ^ dv[i]) : ~(q[i-1] ^ dv[i]);
                end
                if (w[9]) q = ~q;
                if (q == w[7:0]) begin
                    result = dv;
                    found  = 1;
                end
            end
        end
        return result;
    endfunction

    // advance the model by one clock with the given inputs and queue the expected outputs
    task automatic model_step(input logic rst, input logic [9:0] raw);
        obs_t        e;
        logic [19:0] pair;
        logic [9:0]  next_word;
        int          code;
        int          run_after;
        bit          tok;
        bit          reached;
        bit          expired;
        bit          moved;
        moved = 0;
        if (rst) begin
            m_prev = '0; m_word = '0; m_off = 0; m_run = 0; m_timer = 0;
            m_lock = 0; m_seen = 0; m_data = '0; m_de = 1'b0; m_ctrl = 2'b00;
        end else begin
            code      = token_of(m_word);
            tok       = (code >= 0);
            run_after = tok ? ((m_run + 1 > int'(LOCK)) ? int'(LOCK) : m_run + 1) : 0;
            reached   = tok && (m_run == int'(LOCK) - 1);
            expired   = (m_timer == int'(WIN) - 1);
            m_timer   = (m_timer + 1) % int'(WIN);
            if (reached) begin
                if (!m_lock) begin
                    m_lock  = 1;
                    m_timer = 0;
                end else begin
                    m_seen = 1;
                end
            end else if (expired) begin
                if (m_lock && m_seen) begin
                    m_seen = 0;
                end else begin
                    m_lock = 0;
                    moved  = 1;
                end
            end
            pair      = {raw, m_prev};
            next_word = 10'(pair >> m_off);
            if (moved) begin
                m_off     = (m_off + 1) % 10;
                run_after = 0;
                m_timer   = 0;
            end
            m_run = run_after;
            if (!m_lock) begin
                m_data = '0; m_de = 1'b0; m_ctrl = 2'b00;
            end else if (tok) begin
                m_de = 1'b0; m_ctrl = 2'(code);
            end else begin
                m_de = 1'b1; m_data = ref_decode(m_word);
            end
            m_word = next_word;
            m_prev = raw;
        end
        e.data   = m_data;
        e.de     = m_de;
        e.ctrl   = m_ctrl;
        e.locked = m_lock;
        e.offset = 4'(m_off);
        e.slip   = moved;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic [9:0] raw);
        @(negedge clk);
        i_reset   = rst;
        i_sym_in  = raw;
        drive_cyc = cyc + 1;
        model_step(rst, raw);
    endtask

    // send one true symbol through a link whose word boundary is rot bits late
    task automatic send(input logic [9:0] t);
        logic [9:0] raw;
        raw      = 10'({t, last_sym} >> (10 - rot));
        last_sym = t;
        drive(1'b0, raw);
    endtask

    task automatic send_line(input bit rand_data);
        for (int k = 0; k < int'(LINE_TOK); k++) send(10'h354);
        for (int k = 0; k < int'(LINE_DATA); k++) begin
            if (rand_data) send(10'($urandom_range(0, 1023)));
            else           send((k % 2 == 0) ? 10'h100 : 10'h0FF);
        end
    endtask

    task automatic reset_dut(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 10'($urandom_range(0, 1023)));
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // monitor: one expected record per clock, plus event bookkeeping for directed checks
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.data = o_data; a.de = o_de; a.ctrl = o_ctrl;
                a.locked = o_locked; a.offset = o_offset; a.slip = o_slip;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got data=%h de=%b ctrl=%b locked=%b offset=%0d slip=%b expected data=%h de=%b ctrl=%b locked=%b offset=%0d slip=%b",
                             cyc, a.data, a.de, a.ctrl, a.locked, a.offset, a.slip,
                             e.data, e.de, e.ctrl, e.locked, e.offset, e.slip);
                end
            end
            if (o_slip === 1'b1) begin
                slip_cnt++;
                slip_cyc.push_back(cyc);
            end
            if (o_locked === 1'b1 && prev_locked === 1'b0) lock_rise_cyc = cyc;
            if (o_locked === 1'b0 && prev_locked === 1'b1) begin
                fall_cnt++;
                fall_off  = int'(o_offset);
                fall_slip = int'(o_slip);
            end
            prev_locked = o_locked;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e8;
        i_reset  = 1'b1;
        i_sym_in = '0;
        e8       = 0;

        // reset with random input
        reset_dut(3);
        @(posedge clk); #1;
        check("reset locked", int'(o_locked), 0);
        check("reset offset", int'(o_offset), 0);
        check("reset de", int'(o_de), 0);
        check("reset data", int'(o_data), 0);
        check("reset ctrl", int'(o_ctrl), 0);
        check("reset slip", int'(o_slip), 0);

        // aligned stream
        rot = 0;
        slip_cnt = 0;
        lock_rise_cyc = -1;
        for (int k = 0; k < int'(LINE_TOK); k++) begin
            send(10'h354);
            if (k == int'(LOCK) - 1) e8 = drive_cyc;
        end
        for (int k = 0; k < int'(LINE_DATA); k++) send((k % 2 == 0) ? 10'h100 : 10'h0FF);
        repeat (3) send_line(1'b0);
        check("aligned lock latency", lock_rise_cyc, e8 + 2);
        check("aligned locked", int'(o_locked), 1);
        check("aligned offset", int'(o_offset), 0);
        check("aligned slips", slip_cnt, 0);

        // data only: lock must be lost at a window expiry with no run
        fall_cnt = 0;
        repeat (600) send(10'h100);
        check("dataonly falls", fall_cnt, 1);
        check("dataonly fall offset", fall_off, 1);
        check("dataonly fall slip", fall_slip, 1);

        // relock on random-data lines, then control-token bursts
        reset_dut(3);
        rot = 0;
        repeat (3) send_line(1'b1);
        check("random lines locked", int'(o_locked), 1);
        repeat (10) send(10'h2AB);
        send(10'h0AB);
        @(posedge clk); #1;
        check("c11 de", int'(o_de), 0);
        check("c11 ctrl", int'(o_ctrl), 3);
        send(10'h0AB);
        send(10'h0AB);
        @(posedge clk); #1;
        check("c01 ctrl", int'(o_ctrl), 1);
        check("c01 de", int'(o_de), 0);
        repeat (2) send_line(1'b1);

        // stream rotated by 3 bits
        reset_dut(3);
        rot = 3;
        slip_cnt = 0;
        slip_cyc.delete();
        repeat (20) send_line(1'b0);
        check("rot3 slips", slip_cnt, 3);
        if (slip_cyc.size() >= 3) begin
            check("rot3 interval1", slip_cyc[1] - slip_cyc[0], int'(WIN));
            check("rot3 interval2", slip_cyc[2] - slip_cyc[1], int'(WIN));
        end
        check("rot3 offset", int'(o_offset), 3);
        check("rot3 locked", int'(o_locked), 1);

        // lock at offset 7, then reset mid-operation
        reset_dut(3);
        rot = 7;
        repeat (34) send_line(1'b0);
        check("rot7 locked", int'(o_locked), 1);
        check("rot7 offset", int'(o_offset), 7);
        drive(1'b1, 10'($urandom_range(0, 1023)));
        @(posedge clk); #1;
        check("midreset locked", int'(o_locked), 0);
        check("midreset offset", int'(o_offset), 0);
        check("midreset de", int'(o_de), 0);
        reset_dut(2);

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
